// File: rtl/cube_move_if.sv
// Button/frame/limit inputs and X-counter enables exchanged with the move controller.
interface cube_move_if;
    logic btnL;
    logic btnR;
    logic frame;
    logic load_req;
    logic at_right;
    logic at_left;
    logic UP;
    logic DW;
    logic LD;
    logic moving;

    modport master (
        output btnL, btnR, frame, load_req, at_right, at_left,
        input  UP, DW, LD, moving
    );

    modport slave (
        input  btnL, btnR, frame, load_req, at_right, at_left,
        output UP, DW, LD, moving
    );
endinterface

// File: rtl/cube_move_ctrl.sv
// Turns debounced left/right buttons into per-frame bursts of X-counter up/down
// pulses, with respawn loads and hard stops at the playfield limits.
module cube_move_ctrl #(
    parameter int STEP = 2,
    parameter int DBNC = 4
) (
    input logic         clk,
    input logic         reset,
    cube_move_if.slave  bus
);
    localparam int             DCW      = (DBNC > 1) ? $clog2(DBNC) : 1;
    localparam logic [DCW-1:0] DCNT_MAX = DCW'(DBNC - 1);
    localparam logic [2:0]     STEP_N   = 3'(STEP);

    typedef enum logic [1:0] {IDLE, BURST_R, BURST_L, LOAD} state_t;

    logic           l_sync_p0, l_sync_p1, r_sync_p0, r_sync_p1;
    logic           l_deb, r_deb;
    logic [DCW-1:0] l_cnt, r_cnt;
    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           up_q, up_d, dw_q, dw_d, ld_q, ld_d;

    // synchronizer stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_sync_p0 <= 1'b0;
            l_sync_p1 <= 1'b0;
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            l_sync_p0 <= bus.btnL;
            l_sync_p1 <= l_sync_p0;
            r_sync_p0 <= bus.btnR;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // debounce: level flips on the DBNC-th consecutive frame that disagrees with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_cnt <= '0;
            l_deb <= 1'b0;
        end else if (bus.frame) begin
            if (l_sync_p1 == l_deb) begin
                l_cnt <= '0;
            end else if (l_cnt == DCNT_MAX) begin
                l_deb <= l_sync_p1;
                l_cnt <= '0;
            end else begin
                l_cnt <= l_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else if (bus.frame) begin
            if (r_sync_p1 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == DCNT_MAX) begin
                r_deb <= r_sync_p1;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            up_q    <= 1'b0;
            dw_q    <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            dw_q    <= dw_d;
            ld_q    <= ld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        up_d    = 1'b0;
        dw_d    = 1'b0;
        ld_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_req) begin
                    state_d = LOAD;
                    ld_d    = 1'b1;
                    cnt_d   = 3'd0;
                end else if (bus.frame && r_deb && !l_deb && !bus.at_right) begin
                    state_d = BURST_R;
                    up_d    = 1'b1;
                    cnt_d   = 3'd1;
                end else if (bus.frame && l_deb && !r_deb && !bus.at_left) begin
                    state_d = BURST_L;
                    dw_d    = 1'b1;
                    cnt_d   = 3'd1;
                end
            end
            BURST_R: begin
                if (bus.load_req) begin
                    state_d = LOAD;
                    ld_d    = 1'b1;
                    cnt_d   = 3'd0;
                end else if (bus.at_right || cnt_q == STEP_N) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    up_d    = 1'b1;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            BURST_L: begin
                if (bus.load_req) begin
                    state_d = LOAD;
                    ld_d    = 1'b1;
                    cnt_d   = 3'd0;
                end else if (bus.at_left || cnt_q == STEP_N) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    dw_d    = 1'b1;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // pulse already in flight is killed the cycle the limit flag rises
    assign bus.UP     = up_q & ~bus.at_right;
    assign bus.DW     = dw_q & ~bus.at_left;
    assign bus.LD     = ld_q;
    assign bus.moving = (state_q == BURST_R) || (state_q == BURST_L);
endmodule

// File: tb/tb_cube_move_ctrl.sv
// Directed bench for cube_move_ctrl driving a behavioural X counter (0..605).
module tb_cube_move_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cube_move_if bus();

    cube_move_ctrl #(.STEP(2), .DBNC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int x = 0;
    int load_val = 0;
    always @(posedge clk) begin
        if (bus.LD)      x <= load_val;
        else if (bus.UP) x <= x + 1;
        else if (bus.DW) x <= x - 1;
    end
    assign bus.at_right = (x == 605);
    assign bus.at_left  = (x == 0);

    int nvec = 0;
    int nbad = 0;
    int up_seen = 0;
    int dw_seen = 0;
    int excl_bad = 0;
    int range_bad = 0;

    typedef struct {
        string name;
        bit    l;
        bit    r;
        int    x0;
        int    frames;
        int    exp_up;
        int    exp_dw;
        int    exp_x;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (bus.UP) up_seen++;
        if (bus.DW) dw_seen++;
        if (int'(bus.UP) + int'(bus.DW) + int'(bus.LD) > 1) excl_bad = 1;
        if (x < 0 || x > 605) range_bad = 1;
    endtask

    task automatic run_frame();
        repeat (3) cycle();
        bus.frame = 1'b1;
        cycle();
        bus.frame = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic do_reset();
        bus.btnL = 1'b0;
        bus.btnR = 1'b0;
        bus.frame = 1'b0;
        bus.load_req = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
    endtask

    task automatic set_x(input int v);
        load_val = v;
        bus.load_req = 1'b1;
        cycle();
        bus.load_req = 1'b0;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{"r_x100",   1'b0, 1'b1, 100, 10, 12, 0, 112};
        tbl[1] = '{"r_x604",   1'b0, 1'b1, 604, 10,  1, 0, 605};
        tbl[2] = '{"r_x600",   1'b0, 1'b1, 600, 10,  5, 0, 605};
        tbl[3] = '{"l_x1",     1'b1, 1'b0,   1, 10,  0, 1,   0};
        tbl[4] = '{"l_x0",     1'b1, 1'b0,   0, 10,  0, 0,   0};
        tbl[5] = '{"both",     1'b1, 1'b1, 100, 10,  0, 0, 100};
        tbl[6] = '{"none",     1'b0, 1'b0, 100, 10,  0, 0, 100};
        tbl[7] = '{"l_dbnc4",  1'b1, 1'b0, 100,  4,  0, 0, 100};
        tbl[8] = '{"l_dbnc5",  1'b1, 1'b0, 100,  5,  0, 2,  98};

        // asynchronous reset, checked before any clock edge
        bus.btnL = 1'b0;
        bus.btnR = 1'b0;
        bus.frame = 1'b0;
        bus.load_req = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_UP", int'(bus.UP), 0);
        check("rst_DW", int'(bus.DW), 0);
        check("rst_LD", int'(bus.LD), 0);
        check("rst_moving", int'(bus.moving), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_reset();
            set_x(tbl[i].x0);
            up_seen = 0;
            dw_seen = 0;
            bus.btnL = tbl[i].l;
            bus.btnR = tbl[i].r;
            repeat (tbl[i].frames) run_frame();
            check({tbl[i].name, "_up"}, up_seen, tbl[i].exp_up);
            check({tbl[i].name, "_dw"}, dw_seen, tbl[i].exp_dw);
            check({tbl[i].name, "_x"}, x, tbl[i].exp_x);
            bus.btnL = 1'b0;
            bus.btnR = 1'b0;
        end

        // load_req in first burst cycle aborts the burst
        do_reset();
        set_x(100);
        bus.btnR = 1'b1;
        repeat (4) run_frame();
        repeat (3) cycle();
        check("abort_pre_UP", int'(bus.UP), 0);
        bus.frame = 1'b1;
        cycle();
        bus.frame = 1'b0;
        check("abort_UP1", int'(bus.UP), 1);
        load_val = 200;
        bus.load_req = 1'b1;
        cycle();
        bus.load_req = 1'b0;
        check("abort_LD", int'(bus.LD), 1);
        check("abort_UP_off", int'(bus.UP), 0);
        cycle();
        check("abort_LD_once", int'(bus.LD), 0);
        check("abort_UP_idle", int'(bus.UP), 0);
        check("abort_moving", int'(bus.moving), 0);
        cycle();
        check("abort_x", x, 200);

        // cycle-accurate burst shape
        repeat (3) cycle();
        bus.frame = 1'b1;
        cycle();
        bus.frame = 1'b0;
        check("burst_c1_UP", int'(bus.UP), 1);
        check("burst_c1_moving", int'(bus.moving), 1);
        cycle();
        check("burst_c2_UP", int'(bus.UP), 1);
        cycle();
        check("burst_c3_UP", int'(bus.UP), 0);
        check("burst_c3_moving", int'(bus.moving), 0);
        check("burst_x", x, 202);

        // second frame tick inside a burst is not queued
        up_seen = 0;
        repeat (3) cycle();
        bus.frame = 1'b1;
        cycle();
        bus.frame = 1'b1;
        cycle();
        bus.frame = 1'b0;
        repeat (4) cycle();
        check("noqueue_up", up_seen, 2);
        check("noqueue_x", x, 204);
        bus.btnR = 1'b0;

        // reset mid BURST_L
        do_reset();
        set_x(100);
        bus.btnL = 1'b1;
        dw_seen = 0;
        repeat (4) run_frame();
        check("rstl_dbnc_dw", dw_seen, 0);
        repeat (3) cycle();
        bus.frame = 1'b1;
        cycle();
        bus.frame = 1'b0;
        check("rstl_DW1", int'(bus.DW), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rstl_DW_async", int'(bus.DW), 0);
        check("rstl_moving_async", int'(bus.moving), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dw_seen = 0;
        repeat (4) run_frame();
        check("rstl_fresh_dbnc", dw_seen, 0);
        run_frame();
        check("rstl_after_dbnc", dw_seen, 2);
        bus.btnL = 1'b0;

        check("exclusive_outputs", excl_bad, 0);
        check("x_in_range", range_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
